bet_collector: RTL
==================

Name: bet_collector

Overview:
- Upstream stage of the register file's bet inputs; replaces the ad-hoc bet latching and counting at the top level.
- Takes decoded keyboard bet opcodes from the PS/2 path and the chip colour/amount code from the Arduino header.
- Accepts validated bets into a 12-entry packed buffer and presents that buffer, the bet count and a bet-received indicator to the register file.
- Issues a one-cycle spin request, locks the buffer during the spin, and clears it when the processor signals spin completion.

Parameters:
- MAX_BETS, 12, number of bet slots (1..31).
- HOLD_CYCLES, 100000000, cycles bet_ack stays high after an accepted bet (2 s at 50 MHz; bench uses 8).
- SPIN_OPCODE, 6'b111110, keyboard opcode meaning "spin".
- NONE_OPCODE, 6'b111111, keyboard opcode meaning "no valid key".

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle pulse from PS/2 controller: new key decoded.
- bet_opcode  in  6  bet opcode for the current key (valid with rx_valid).
- chip_color  in  3  Arduino chip sensor; [2]=chip present, [1:0]=amount code.
- spin_done  in  1  one-cycle pulse from processor-side logic: payout finished.
- bets_flat  out  8*MAX_BETS  slot i at bits [8i+7:8i], formatted {amount[1:0], opcode[5:0]}.
- bet_count  out  5  number of filled slots, 0..MAX_BETS.
- full  out  1  bet_count == MAX_BETS.
- spin_req  out  1  one-cycle pulse when a spin is accepted.
- spinning  out  1  high while in SPIN state.
- bet_ack  out  1  high for HOLD_CYCLES after each accepted bet.
- rejected  out  1  one-cycle pulse when an rx_valid bet or spin is refused.

Behaviour:
- Reset (async, any state): state=COLLECT; all slots, bet_count, spin_req, rejected, bet_ack and the hold counter = 0. All outputs are registered.
- States: COLLECT, SPIN, CLEAR.
- COLLECT, bet accept condition:
  - rx_valid=1, bet_opcode ∉ {SPIN_OPCODE, NONE_OPCODE}, chip_color[2]=1, full=0.
  - Next edge: slot[bet_count] <= {chip_color[1:0], bet_opcode}; bet_count++.
  - Result visible one cycle after the rx_valid cycle.
- COLLECT, bet refusal:
  - rx_valid with a non-spin/non-none opcode and chip_color[2]=0 or full=1: pulse rejected, no state change.
  - rx_valid with NONE_OPCODE is ignored silently (no rejected pulse).
- COLLECT, spin:
  - rx_valid with SPIN_OPCODE and bet_count>0: -> SPIN; spin_req=1 for exactly one cycle (the first cycle in SPIN).
  - rx_valid with SPIN_OPCODE and bet_count==0: pulse rejected, stay in COLLECT.
- SPIN:
  - Buffer and bet_count frozen; spinning=1.
  - Any rx_valid pulses rejected (including spin).
  - spin_done -> CLEAR.
  - spin_done and rx_valid in the same cycle: spin_done wins; the key is rejected.
- CLEAR (one cycle): all slots and bet_count <= 0, then -> COLLECT.
  - rx_valid during CLEAR is rejected.
  - spin_done outside SPIN is ignored.
- bet_ack:
  - On each accepted bet, the hold counter loads HOLD_CYCLES and bet_ack=1 from the next edge.
  - The counter decrements each cycle; bet_ack drops on the edge where the counter reaches 0, so the high time is exactly HOLD_CYCLES cycles.
  - A new accept retriggers (reloads) the counter.
  - Spin and clear do not affect bet_ack.
- Width rules: bet_count saturates at MAX_BETS (no wrap); the counter is 27 bits.
- Outputs spinning and full are decoded from registered state (no input-to-output combinational path).

Test Plan:
1. Reset mid-SPIN with 3 bets stored -> next cycle bet_count=0, spinning=0, bets_flat=0, bet_ack=0.
2. rx_valid, opcode=6'd5, chip_color=3'b110 -> slot0=8'b10_000101, bet_count=1; bet_ack high for exactly 8 cycles (HOLD_CYCLES=8).
3. Fill 12 bets, then a 13th with chip_color=3'b101 -> rejected pulse, full=1, bet_count stays 12, slot 11 unchanged.
4. Bet with chip_color=3'b001 -> rejected, bet_count unchanged; SPIN_OPCODE with bet_count=0 -> rejected, spin_req=0.
5. 2 bets, then SPIN_OPCODE -> single-cycle spin_req, spinning=1; a further bet is rejected; spin_done -> one CLEAR cycle, then COLLECT with bet_count=0.
6. In SPIN, spin_done and rx_valid bet in the same cycle -> rejected=1, state CLEAR, buffer cleared; a bet two cycles later is accepted into slot0.

Source files
------------

// File: rtl/bet_collector_if.sv
// Bet collector bus: keyboard/chip inputs in, packed bet buffer and status out.
// Latency: wires only; timing is set by the collector behind the slave modport.
// Backpressure: none; refused keys are reported on the rejected pulse.
interface bet_collector_if #(
    parameter int MAX_BETS = 12
);
    logic                    rx_valid;
    logic [5:0]              bet_opcode;
    logic [2:0]              chip_color;
    logic                    spin_done;
    logic [8*MAX_BETS-1:0]   bets_flat;
    logic [4:0]              bet_count;
    logic                    full;
    logic                    spin_req;
    logic                    spinning;
    logic                    bet_ack;
    logic                    rejected;

    modport slave (
        input  rx_valid, bet_opcode, chip_color, spin_done,
        output bets_flat, bet_count, full, spin_req, spinning, bet_ack, rejected
    );

    modport master (
        output rx_valid, bet_opcode, chip_color, spin_done,
        input  bets_flat, bet_count, full, spin_req, spinning, bet_ack, rejected
    );
endinterface

// File: rtl/bet_collector.sv
// Bet collector: latches validated keyboard bets into a packed slot buffer and sequences spins.
// Latency: every output is registered; a key's effect appears one cycle after its rx_valid cycle.
// Backpressure: none; refused keys (no chip, buffer full, locked during spin) pulse rejected.
module bet_collector #(
    parameter int          MAX_BETS    = 12,
    parameter int          HOLD_CYCLES = 100000000,
    parameter logic [5:0]  SPIN_OPCODE = 6'b111110,
    parameter logic [5:0]  NONE_OPCODE = 6'b111111
) (
    input  logic             clock,
    input  logic             reset,
    bet_collector_if.slave   bus
);
    typedef enum logic [1:0] {COLLECT, SPIN, CLEAR} state_t;

    state_t                state;
    state_t                state_next;
    logic [8*MAX_BETS-1:0] bets_q;
    logic [4:0]            count_q;
    logic [26:0]           hold_q;
    logic                  ack_q;
    logic                  spin_req_q;
    logic                  rejected_q;
    logic                  full_int;
    logic                  is_bet;
    logic                  accept;
    logic                  spin_go;
    logic                  reject;
    logic                  clear_buf;

    assign full_int = (count_q == 5'(MAX_BETS));
    assign is_bet   = (bus.bet_opcode != SPIN_OPCODE) && (bus.bet_opcode != NONE_OPCODE);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle decisions: accept, spin, reject, clear.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        spin_go    = 1'b0;
        reject     = 1'b0;
        clear_buf  = 1'b0;
        case (state)
            COLLECT: begin
                if (bus.rx_valid) begin
                    if (bus.bet_opcode == SPIN_OPCODE) begin
                        if (count_q != 5'd0) begin
                            spin_go    = 1'b1;
                            state_next = SPIN;
                        end else begin
                            reject = 1'b1;
                        end
                    end else if (is_bet) begin
                        if (bus.chip_color[2] && !full_int) begin
                            accept = 1'b1;
                        end else begin
                            reject = 1'b1;
                        end
                    end
                end
            end
            SPIN: begin
                // Buffer is locked; every key is refused, even alongside spin_done.
                reject = bus.rx_valid;
                if (bus.spin_done) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                reject     = bus.rx_valid;
                clear_buf  = 1'b1;
                state_next = COLLECT;
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    // Bet buffer, count and one-cycle status pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bets_q     <= '0;
            count_q    <= 5'd0;
            spin_req_q <= 1'b0;
            rejected_q <= 1'b0;
        end else begin
            spin_req_q <= spin_go;
            rejected_q <= reject;
            if (clear_buf) begin
                bets_q  <= '0;
                count_q <= 5'd0;
            end else if (accept) begin
                for (int i = 0; i < MAX_BETS; i++) begin
                    if (count_q == 5'(i)) begin
                        bets_q[8*i +: 8] <= {bus.chip_color[1:0], bus.bet_opcode};
                    end
                end
                count_q <= count_q + 5'd1;
            end
        end
    end

    // Acknowledge hold: reload on each accept, drop when the counter reaches zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q <= 27'd0;
            ack_q  <= 1'b0;
        end else if (accept) begin
            hold_q <= 27'(HOLD_CYCLES);
            ack_q  <= (HOLD_CYCLES != 0);
        end else if (hold_q != 27'd0) begin
            hold_q <= hold_q - 27'd1;
            ack_q  <= (hold_q != 27'd1);
        end
    end

    assign bus.bets_flat = bets_q;
    assign bus.bet_count = count_q;
    assign bus.full      = full_int;
    assign bus.spin_req  = spin_req_q;
    assign bus.spinning  = (state == SPIN);
    assign bus.bet_ack   = ack_q;
    assign bus.rejected  = rejected_q;
endmodule
